// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU operation codes and the EX/MEM control bundle.
// Compare ops occupy the 10xx code space; 1001 doubles as SRAI outside branches.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_EQ   = 4'b1000,
    ALU_NE   = 4'b1001,
    ALU_LT   = 4'b1010,
    ALU_GE   = 4'b1011,
    ALU_SLLI = 4'b1101,
    ALU_SRLI = 4'b1110
  } alu_op_e;

  localparam alu_op_e ALU_SRAI = ALU_NE;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
  } ex_mem_t;

  function automatic logic is_compare_op(input logic [3:0] op);
    return op inside {ALU_EQ, ALU_NE, ALU_LT, ALU_GE};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump decision from the ALU compare result.
// The compare result lives in bit 0 of the ALU output.
module branch_resolve
  import pipe_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic                     result_lsb,
  input  logic                     branch,
  input  logic                     jump,
  output logic                     taken
);

  // Compare codes only mean "compare" when the instruction is a branch.
  assign taken = jump || (branch && is_compare_op(op) && result_lsb);

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: resolves branches, raises a same-cycle redirect/flush,
// and registers the EX bundle with stall hold, bubble insertion and debug counters.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [OPCODE_LENGTH-1:0] ex_op,
  input  logic [DATA_WIDTH-1:0]    ex_alu_result,
  input  logic                     ex_branch,
  input  logic                     ex_jump,
  input  logic [DATA_WIDTH-1:0]    ex_target,
  input  logic [DATA_WIDTH-1:0]    ex_pc_plus4,
  input  logic [DATA_WIDTH-1:0]    ex_store_data,
  input  logic [4:0]               ex_rd,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     mem_stall,
  output logic                     pc_redirect,
  output logic [DATA_WIDTH-1:0]    pc_target,
  output logic                     flush,
  output logic                     mem_valid,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [DATA_WIDTH-1:0]    mem_store_data,
  output logic [DATA_WIDTH-1:0]    mem_pc_plus4,
  output logic [4:0]               mem_rd,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic                     mem_mem_write,
  output logic                     mem_jump,
  output logic [CNT_WIDTH-1:0]     cnt_retired,
  output logic [CNT_WIDTH-1:0]     cnt_taken
);

  logic acc;
  logic taken;

  ex_mem_t               ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [CNT_WIDTH-1:0]  cnt_retired_q, cnt_retired_d;
  logic [CNT_WIDTH-1:0]  cnt_taken_q, cnt_taken_d;

  assign acc      = ex_valid && !mem_stall;
  assign ex_ready = !mem_stall;

  branch_resolve #(
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_branch_resolve (
    .op         (ex_op),
    .result_lsb (ex_alu_result[0]),
    .branch     (ex_branch),
    .jump       (ex_jump),
    .taken      (taken)
  );

  // Gated by reset so no redirect escapes while the pipeline is being cleared.
  assign pc_redirect = reset && acc && taken;
  assign flush       = pc_redirect;
  assign pc_target   = ex_target;

  always_comb begin
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    pc_plus4_d   = pc_plus4_q;
    if (!mem_stall) begin
      if (ex_valid) begin
        ctrl_d.valid     = 1'b1;
        ctrl_d.rd        = ex_rd;
        ctrl_d.reg_write = ex_reg_write;
        ctrl_d.mem_read  = ex_mem_read;
        ctrl_d.mem_write = ex_mem_write;
        ctrl_d.jump      = ex_jump;
        alu_result_d     = ex_alu_result;
        store_data_d     = ex_store_data;
        pc_plus4_d       = ex_pc_plus4;
      end else begin
        // Bubble: kill side effects, leave data fields untouched.
        ctrl_d.valid     = 1'b0;
        ctrl_d.reg_write = 1'b0;
        ctrl_d.mem_read  = 1'b0;
        ctrl_d.mem_write = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_retired_d = cnt_retired_q;
    cnt_taken_d   = cnt_taken_q;
    if (acc && (cnt_retired_q != '1)) cnt_retired_d = cnt_retired_q + 1'b1;
    if (pc_redirect && (cnt_taken_q != '1)) cnt_taken_d = cnt_taken_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q       <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_retired_q <= '0;
      cnt_taken_q   <= '0;
    end else begin
      cnt_retired_q <= cnt_retired_d;
      cnt_taken_q   <= cnt_taken_d;
    end
  end

  assign mem_valid      = ctrl_q.valid;
  assign mem_rd         = ctrl_q.rd;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_mem_write  = ctrl_q.mem_write;
  assign mem_jump       = ctrl_q.jump;
  assign mem_alu_result = alu_result_q;
  assign mem_store_data = store_data_q;
  assign mem_pc_plus4   = pc_plus4_q;
  assign cnt_retired    = cnt_retired_q;
  assign cnt_taken      = cnt_taken_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the stage.
module tb_ex_mem_stage;

  localparam int DW   = 32;
  localparam int OPL  = 4;
  localparam int CW   = 8;   // narrow counters so saturation is reached quickly
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           ex_valid, ex_ready;
  logic [OPL-1:0] ex_op;
  logic [DW-1:0]  ex_alu_result, ex_target, ex_pc_plus4, ex_store_data;
  logic           ex_branch, ex_jump;
  logic [4:0]     ex_rd;
  logic           ex_reg_write, ex_mem_read, ex_mem_write, mem_stall;
  logic           pc_redirect, flush;
  logic [DW-1:0]  pc_target;
  logic           mem_valid;
  logic [DW-1:0]  mem_alu_result, mem_store_data, mem_pc_plus4;
  logic [4:0]     mem_rd;
  logic           mem_reg_write, mem_mem_read, mem_mem_write, mem_jump;
  logic [CW-1:0]  cnt_retired, cnt_taken;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit             m_valid, m_rw, m_mr, m_mw, m_jump;
  logic [DW-1:0]  m_alu, m_store, m_pc4;
  logic [4:0]     m_rd;
  int             m_ret, m_tkn;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OPL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_alu_result(ex_alu_result), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .mem_stall(mem_stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_jump(mem_jump),
    .cnt_retired(cnt_retired), .cnt_taken(cnt_taken)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect rule: accepted jump, or accepted branch whose op is EQ/NE/LT/GE with a true compare.
  function automatic bit model_taken();
    if (reset !== 1'b1) return 1'b0;
    if (!ex_valid || mem_stall) return 1'b0;
    if (ex_jump) return 1'b1;
    if (ex_branch) begin
      case (ex_op)
        4'd8, 4'd9, 4'd10, 4'd11: return ex_alu_result[0];
        default:                  return 1'b0;
      endcase
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_jump = 0;
    m_alu = '0; m_store = '0; m_pc4 = '0; m_rd = '0;
    m_ret = 0; m_tkn = 0;
  endtask

  task automatic model_update();
    bit red;
    red = model_taken();
    if (ex_valid && !mem_stall) m_ret = (m_ret == CMAX) ? CMAX : m_ret + 1;
    if (red) m_tkn = (m_tkn == CMAX) ? CMAX : m_tkn + 1;
    if (!mem_stall) begin
      if (ex_valid) begin
        m_valid = 1; m_alu = ex_alu_result; m_store = ex_store_data; m_pc4 = ex_pc_plus4;
        m_rd = ex_rd; m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
        m_jump = ex_jump;
      end else begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      end
    end
  endtask

  task automatic check_all();
    bit red;
    red = model_taken();
    chk("ex_ready", ex_ready, !mem_stall);
    chk("pc_redirect", pc_redirect, red);
    chk("flush", flush, red);
    chk("pc_target", pc_target, ex_target);
    chk("mem_valid", mem_valid, m_valid);
    chk("mem_alu_result", mem_alu_result, m_alu);
    chk("mem_store_data", mem_store_data, m_store);
    chk("mem_pc_plus4", mem_pc_plus4, m_pc4);
    chk("mem_rd", mem_rd, m_rd);
    chk("mem_reg_write", mem_reg_write, m_rw);
    chk("mem_mem_read", mem_mem_read, m_mr);
    chk("mem_mem_write", mem_mem_write, m_mw);
    chk("mem_jump", mem_jump, m_jump);
    chk("cnt_retired", cnt_retired, m_ret);
    chk("cnt_taken", cnt_taken, m_tkn);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [DW-1:0] res,
                       input bit br, input bit jp, input logic [DW-1:0] tgt,
                       input logic [4:0] rd, input bit rw, input bit stall);
    ex_valid = v; ex_op = op; ex_alu_result = res; ex_branch = br; ex_jump = jp;
    ex_target = tgt; ex_rd = rd; ex_reg_write = rw; ex_mem_read = 0; ex_mem_write = 0;
    ex_pc_plus4 = $urandom; ex_store_data = $urandom; mem_stall = stall;
  endtask

  // Compare this cycle's outputs, then let the edge happen and advance the model.
  task automatic clock_cycle();
    #1 check_all();
    @(posedge clk);
    #1 model_update();
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    drive(1, 4'b0000, 32'h0, 0, 1, 32'h200, 5'd1, 1, 0);  // jump presented during reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_alu_result", mem_alu_result, 0);
    chk("rst_cnt_retired", cnt_retired, 0);
    chk("rst_pc_redirect", pc_redirect, 0);
    chk("rst_flush", flush, 0);

    @(negedge clk);
    reset = 1'b1;
    drive(1, 4'b0010, 32'h7, 0, 0, 32'h0, 5'd5, 1, 0);   // ADD
    clock_cycle();
    chk("add_mem_alu_result", mem_alu_result, 32'h7);
    chk("add_mem_rd", mem_rd, 5);
    chk("add_mem_valid", mem_valid, 1);

    @(negedge clk);
    drive(1, 4'b1000, 32'h1, 1, 0, 32'h100, 5'd0, 0, 0); // BEQ taken
    #1;
    chk("beq_redirect", pc_redirect, 1);
    chk("beq_flush", flush, 1);
    chk("beq_target", pc_target, 32'h100);
    clock_cycle();
    chk("beq_cnt_taken", cnt_taken, 1);

    @(negedge clk);
    drive(1, 4'b1000, 32'h0, 1, 0, 32'h100, 5'd0, 0, 0); // BEQ not taken
    #1 chk("beq_nt_redirect", pc_redirect, 0);
    clock_cycle();

    @(negedge clk);
    drive(1, 4'b1001, 32'h1, 0, 0, 32'h140, 5'd9, 1, 0); // SRAI
    #1 chk("srai_redirect", pc_redirect, 0);
    clock_cycle();

    @(negedge clk);
    drive(1, 4'b1001, 32'h1, 1, 0, 32'h180, 5'd0, 0, 0); // BNE taken
    #1 chk("bne_redirect", pc_redirect, 1);
    clock_cycle();

    // BLT taken held by a 3-cycle stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 4'b1010, 32'h1, 1, 0, 32'h300, 5'd0, 0, 1);
      #1;
      chk("stall_ready", ex_ready, 0);
      chk("stall_redirect", pc_redirect, 0);
      clock_cycle();
    end
    @(negedge clk);
    mem_stall = 0;
    #1 chk("blt_release_redirect", pc_redirect, 1);
    clock_cycle();
    chk("blt_loaded_valid", mem_valid, 1);
    @(negedge clk);
    drive(1, 4'b0010, 32'h3, 0, 0, 32'h0, 5'd2, 1, 0);
    #1 chk("blt_single_pulse", pc_redirect, 0);
    clock_cycle();

    @(negedge clk);
    drive(0, 4'b0010, 32'h55, 0, 0, 32'h0, 5'd7, 1, 0);  // bubble
    clock_cycle();
    chk("bubble_mem_valid", mem_valid, 0);
    chk("bubble_mem_reg_write", mem_reg_write, 0);

    // randomized traffic, long enough to saturate the counters
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      ex_valid      = ($urandom_range(0, 3) != 0);
      mem_stall     = ($urandom_range(0, 3) == 0);
      ex_op         = 4'($urandom_range(0, 15));
      ex_alu_result = $urandom;
      ex_branch     = $urandom_range(0, 1);
      ex_jump       = ($urandom_range(0, 5) == 0);
      ex_target     = $urandom;
      ex_pc_plus4   = $urandom;
      ex_store_data = $urandom;
      ex_rd         = 5'($urandom);
      ex_reg_write  = $urandom_range(0, 1);
      ex_mem_read   = $urandom_range(0, 1);
      ex_mem_write  = $urandom_range(0, 1);
      clock_cycle();
    end
    chk("sat_cnt_retired", cnt_retired, CMAX);
    @(negedge clk);
    drive(1, 4'b0010, 32'h1, 0, 0, 32'h0, 5'd3, 1, 0);
    clock_cycle();
    chk("sat_hold_cnt_retired", cnt_retired, CMAX);

    // asynchronous reset in the middle of a stalled cycle
    @(negedge clk);
    drive(1, 4'b1011, 32'h1, 1, 0, 32'h400, 5'd4, 1, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_mem_alu_result", mem_alu_result, 0);
    chk("arst_cnt_retired", cnt_retired, 0);
    chk("arst_cnt_taken", cnt_taken, 0);
    mem_stall = 0;
    #1 chk("arst_redirect", pc_redirect, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 4'b0110, 32'hA5, 0, 0, 32'h0, 5'd6, 1, 0);
    clock_cycle();
    chk("post_rst_cnt_retired", cnt_retired, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
